seg_message_sequencer: RTL and testbench

//  Stores a short message of 6-bit glyph codes (0..41, the 7-seg decoder's glyph index) and plays it on the single display.

---
 rtl/seg_message_sequencer.sv | 140 ++++++++++++++
 tb/tb_seg_message_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_message_sequencer.sv
// Message buffer and playback sequencer for a single 7-segment display.
// Stores glyph codes, then plays them back with a fixed dwell and blank gap, one-shot or looping.
module seg_message_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CODE_BITS    = 6,
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [CODE_BITS-1:0]     wr_code,
  output logic                     wr_ready,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic                     busy,
  output logic                     char_valid,
  output logic [CODE_BITS-1:0]     char_code,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned IW       = $clog2(DEPTH);
  localparam int unsigned CW       = IW + 1;
  localparam int unsigned TimerMax = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned TW       = $clog2(TimerMax + 1);
  localparam logic [TW-1:0] DwellLast = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GapLast   = TW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e               r_state;
  logic [IW-1:0]        r_idx;
  logic [TW-1:0]        r_timer;
  logic [CODE_BITS-1:0] r_buf [DEPTH];

  logic          w_idle;
  logic          w_clear;
  logic          w_wr_fire;
  logic [CW-1:0] w_count_nxt;
  logic          w_start;
  logic          w_adv;
  logic          w_has_next;
  logic          w_adv_play;
  logic [IW-1:0] w_adv_idx;

  assign w_idle      = (r_state == StIdle);
  assign w_clear     = clear && w_idle;
  // wr_ready is only ever high in IDLE, and clear wins over a same-cycle write
  assign w_wr_fire   = wr_valid && wr_ready && !w_clear;
  assign w_count_nxt = w_clear ? '0 : (w_wr_fire ? count + CW'(1) : count);
  assign w_start     = w_idle && start && !w_clear && (count != '0);

  // End of one entry's slot: after the gap, or after the dwell when there is no gap
  assign w_adv = ((r_state == StShow) && (r_timer == DwellLast) && (GAP_CYCLES == 0)) ||
                 ((r_state == StGap) && (r_timer == GapLast));
  assign w_has_next = (CW'(r_idx) + CW'(1)) < count;
  assign w_adv_play = w_has_next || loop_en;
  assign w_adv_idx  = w_has_next ? r_idx + IW'(1) : '0;

  always_ff @(posedge clk_2) begin
    if (w_wr_fire) begin
      r_buf[count[IW-1:0]] <= wr_code;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_timer    <= '0;
      count      <= '0;
      busy       <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= '0;
      done       <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      done  <= 1'b0;
      count <= w_count_nxt;
      if (stop) begin
        r_state    <= StIdle;
        busy       <= 1'b0;
        char_valid <= 1'b0;
        char_code  <= '0;
        wr_ready   <= (w_count_nxt < CW'(DEPTH));
      end else if (w_adv) begin
        r_timer <= '0;
        if (w_adv_play) begin
          r_state    <= StShow;
          r_idx      <= w_adv_idx;
          char_valid <= 1'b1;
          char_code  <= r_buf[w_adv_idx];
        end else begin
          r_state    <= StIdle;
          busy       <= 1'b0;
          char_valid <= 1'b0;
          char_code  <= '0;
          done       <= 1'b1;
          wr_ready   <= (count < CW'(DEPTH));
        end
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_start) begin
              r_state    <= StShow;
              r_idx      <= '0;
              r_timer    <= '0;
              busy       <= 1'b1;
              char_valid <= 1'b1;
              char_code  <= r_buf[0];
              wr_ready   <= 1'b0;
            end else begin
              wr_ready <= (w_count_nxt < CW'(DEPTH));
            end
          end
          StShow: begin
            if (r_timer == DwellLast) begin
              r_state    <= StGap;
              r_timer    <= '0;
              char_valid <= 1'b0;
              char_code  <= '0;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          StGap: begin
            r_timer <= r_timer + TW'(1);
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_message_sequencer.sv
// Self-checking bench for seg_message_sequencer: a gapped instance and a gapless instance,
// each checked cycle by cycle against a queue-based model of the expected display trace.
module tb_seg_message_sequencer;

  localparam int Depth = 8;
  localparam int Dwell = 4;
  localparam int Gap   = 1;

  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic       reset, wr_valid, clear, start, stop, loop_en;
  logic [5:0] wr_code;
  logic       wr_ready, busy, char_valid, done;
  logic [5:0] char_code;
  logic [3:0] count;

  logic       b_wr_valid, b_clear, b_start, b_stop, b_loop_en;
  logic [5:0] b_wr_code;
  logic       b_wr_ready, b_busy, b_char_valid, b_done;
  logic [5:0] b_char_code;
  logic [3:0] b_count;

  seg_message_sequencer #(
    .DEPTH(Depth), .CODE_BITS(6), .DWELL_CYCLES(Dwell), .GAP_CYCLES(Gap)
  ) u_dut (
    .clk_2(clk_2), .reset(reset), .wr_valid(wr_valid), .wr_code(wr_code),
    .wr_ready(wr_ready), .clear(clear), .start(start), .stop(stop), .loop_en(loop_en),
    .busy(busy), .char_valid(char_valid), .char_code(char_code), .done(done), .count(count)
  );

  seg_message_sequencer #(
    .DEPTH(Depth), .CODE_BITS(6), .DWELL_CYCLES(Dwell), .GAP_CYCLES(0)
  ) u_dut_nogap (
    .clk_2(clk_2), .reset(reset), .wr_valid(b_wr_valid), .wr_code(b_wr_code),
    .wr_ready(b_wr_ready), .clear(b_clear), .start(b_start), .stop(b_stop),
    .loop_en(b_loop_en), .busy(b_busy), .char_valid(b_char_valid), .char_code(b_char_code),
    .done(b_done), .count(b_count)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic wr(input logic [5:0] c);
    bit acc;
    acc = (mq.size() < Depth);
    chk("wr_ready_before", wr_ready, acc);
    wr_valid = 1'b1;
    wr_code  = c;
    step();
    wr_valid = 1'b0;
    if (acc) mq.push_back(c);
    chk("count_after_wr", count, mq.size());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    mq.delete();
    chk("count_after_clear", count, 0);
  endtask

  // One-shot playback of the model queue on the gapped instance
  task automatic play();
    int n_busy;
    n_busy  = 0;
    loop_en = 1'b0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    foreach (mq[i]) begin
      for (int d = 0; d < Dwell; d++) begin
        chk("show_valid", char_valid, 1);
        chk("show_code", char_code, mq[i]);
        chk("show_done", done, 0);
        if (busy) n_busy++;
        step();
      end
      for (int g = 0; g < Gap; g++) begin
        chk("gap_valid", char_valid, 0);
        chk("gap_code", char_code, 0);
        if (busy) n_busy++;
        step();
      end
    end
    chk("busy_cycles", n_busy, mq.size() * (Dwell + Gap));
    chk("done_pulse", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", char_valid, 0);
    chk("end_count", count, mq.size());
    chk("end_wr_ready", wr_ready, mq.size() < Depth);
    step();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_code = '0; clear = 1'b0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    b_wr_valid = 1'b0; b_wr_code = '0; b_clear = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_loop_en = 1'b0;
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", char_valid, 0);
    chk("rst_code", char_code, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_ready", wr_ready, 1);
    reset = 1'b0;
    step();

    // Directed 3-glyph one-shot
    wr(6'd3); wr(6'd7); wr(6'd12);
    play();
    play();

    // Overfill: ninth write dropped
    do_clear();
    for (int i = 0; i < 9; i++) wr(6'($urandom_range(0, 63)));
    chk("full_wr_ready", wr_ready, 0);
    chk("full_count", count, Depth);
    play();

    // Looping playback interrupted by stop mid-SHOW
    do_clear();
    wr(6'd1); wr(6'd2);
    loop_en = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int r = 0; r < 2; r++) begin
      foreach (mq[i]) begin
        for (int d = 0; d < Dwell; d++) begin
          chk("loop_code", char_code, mq[i]);
          chk("loop_valid", char_valid, 1);
          chk("loop_done", done, 0);
          step();
        end
        for (int g = 0; g < Gap; g++) begin
          chk("loop_gap", char_valid, 0);
          chk("loop_busy", busy, 1);
          step();
        end
      end
    end
    step();
    chk("loop_third_round", char_code, mq[0]);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_valid", char_valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_count", count, 2);
    step();
    chk("stop_no_done", done, 0);
    loop_en = 1'b0;

    // Start with empty buffer
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_start_busy", busy, 0);
    chk("empty_start_valid", char_valid, 0);
    step();
    chk("empty_start_done", done, 0);

    // clear beats a same-cycle write; writes refused during playback
    clear = 1'b1; wr_valid = 1'b1; wr_code = 6'd5;
    step();
    clear = 1'b0; wr_valid = 1'b0;
    chk("clear_vs_write", count, 0);
    wr(6'd10); wr(6'd20);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("show_wr_ready", wr_ready, 0);
    wr_valid = 1'b1; wr_code = 6'd33;
    step();
    wr_valid = 1'b0;
    chk("show_write_dropped", count, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    play();

    // Randomized messages, each played twice to confirm contents survive
    for (int t = 0; t < 5; t++) begin
      int n;
      do_clear();
      n = $urandom_range(1, Depth);
      for (int i = 0; i < n; i++) wr(6'($urandom_range(0, 63)));
      play();
      play();
    end

    // Gapless instance: 5,6 back to back
    b_wr_valid = 1'b1; b_wr_code = 6'd5;
    step();
    b_wr_code = 6'd6;
    step();
    b_wr_valid = 1'b0;
    chk("nogap_count", b_count, 2);
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int c = 0; c < 2 * Dwell; c++) begin
      chk("nogap_valid", b_char_valid, 1);
      chk("nogap_code", b_char_code, (c < Dwell) ? 5 : 6);
      step();
    end
    chk("nogap_done", b_done, 1);
    chk("nogap_end_valid", b_char_valid, 0);

    // Reset mid-SHOW on both instances
    step();
    b_start = 1'b1; start = 1'b1;
    step();
    b_start = 1'b0; start = 1'b0;
    step();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mq.delete();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", char_valid, 0);
    chk("mid_rst_code", char_code, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wr_ready", wr_ready, 1);
    chk("mid_rst_b_count", b_count, 0);
    chk("mid_rst_b_valid", b_char_valid, 0);
    chk("mid_rst_b_busy", b_busy, 0);
    step();
    chk("post_rst_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
